// File: rtl/tt_capture_pkg.sv
// Shared types and width helpers for the truth-table capture engine.
package tt_capture_pkg;

    localparam int N_IN_MAX = 7;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    // One index bit per network input, since the table holds 2^N_IN entries.
    function automatic int idx_width(input int n_in);
        return (n_in < 1) ? 1 : n_in;
    endfunction

endpackage

// File: rtl/tt_capture_if.sv
// Host/network-facing signal bundle of tt_capture; compare signals exist only
// when TT_CAPTURE_CMP_EN is defined.
interface tt_capture_if
    import tt_capture_pkg::*;
#(
    parameter int N_IN = 7
);
    localparam int TT_W = tt_width(N_IN);

    logic            start;
    logic            f_in;
    logic [N_IN-1:0] x_out;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt;

`ifdef TT_CAPTURE_CMP_EN
    localparam int IDX_W = idx_width(N_IN);

    logic [TT_W-1:0]  exp_tt;
    logic             match;
    logic [IDX_W-1:0] mismatch_idx;

    modport master (
        output start, f_in, exp_tt,
        input  x_out, busy, done, tt, match, mismatch_idx
    );

    modport slave (
        input  start, f_in, exp_tt,
        output x_out, busy, done, tt, match, mismatch_idx
    );
`else
    modport master (
        output start, f_in,
        input  x_out, busy, done, tt
    );

    modport slave (
        input  start, f_in,
        output x_out, busy, done, tt
    );
`endif

endinterface

// File: rtl/tt_settle_timer.sv
// 4-bit loadable down-counter; expired is high while the count sits at zero.
module tt_settle_timer
    import tt_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/tt_capture.sv
// Truth-table capture engine: sweeps every input vector through an external network
// and publishes the sampled outputs as one table. TT_CAPTURE_CMP_EN adds an expected-table compare.
module tt_capture
    import tt_capture_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 1,
    parameter int TT_W   = tt_width(N_IN)
) (
    input logic         clk,
    input logic         rst,
    tt_capture_if.slave bus
);

    localparam int                  IDX_W     = idx_width(N_IN);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(TT_W - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_IN-1:0]  x_out_q, x_out_d;
    logic [TT_W-1:0]  shadow_q, shadow_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic             armed_q, armed_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_expired;

    tt_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (SETTLE_LD),
        .expired  (tmr_expired)
    );

    // armed_q blocks a start that coincides with the first edge after reset release.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_out_d  = x_out_q;
        shadow_d = shadow_q;
        tt_d     = tt_q;
        armed_d  = 1'b1;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                x_out_d = '0;
                if (bus.start && armed_q) begin
                    state_d  = RUN;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            RUN: begin
                if (!tmr_expired) begin
                    tmr_en = 1'b1;
                end else begin
                    shadow_d[idx_q] = bus.f_in;
                    if (idx_q == IDX_LAST) begin
                        // Publish the whole table, including the final sample, on the edge entering DONE.
                        state_d = DONE;
                        x_out_d = '0;
                        tt_d    = shadow_d;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        x_out_d  = idx_d;
                        tmr_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                x_out_d = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            x_out_q  <= '0;
            shadow_q <= '0;
            tt_q     <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_out_q  <= x_out_d;
            shadow_q <= shadow_d;
            tt_q     <= tt_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.x_out = x_out_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.tt    = tt_q;

`ifdef TT_CAPTURE_CMP_EN
    logic             match_q, match_d;
    logic [IDX_W-1:0] mismatch_idx_q, mismatch_idx_d;

    function automatic logic [IDX_W-1:0] first_diff(input logic [TT_W-1:0] diff);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                pos = IDX_W'(i);
            end
        end
        return pos;
    endfunction

    // Compare results are taken together with the new table so they are valid during done.
    always_comb begin
        match_d        = match_q;
        mismatch_idx_d = mismatch_idx_q;
        if ((state_q == RUN) && (state_d == DONE)) begin
            match_d        = (tt_d == bus.exp_tt);
            mismatch_idx_d = first_diff(tt_d ^ bus.exp_tt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q        <= 1'b0;
            mismatch_idx_q <= '0;
        end else begin
            match_q        <= match_d;
            mismatch_idx_q <= mismatch_idx_d;
        end
    end

    assign bus.match        = match_q;
    assign bus.mismatch_idx = mismatch_idx_q;
`endif

endmodule
